// File: rtl/abc_instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, issues NVM fetches, presents words to
// execute over valid/ready and applies branch/call/return redirects via a return stack.
module abc_instr_fetch_seq #(
  parameter int          ICWIDTH    = 8,
  parameter int          IWWIDTH    = 58,
  parameter int          SDEPTH     = 4,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ENABLE,
  output logic               NVM_START,
  input  logic               NVM_STALL,
  output logic [ICWIDTH-1:0] NVM_ADDRESS,
  input  logic [IWWIDTH-1:0] NVM_INSTRUCTION,
  output logic               INSTR_VALID,
  output logic [IWWIDTH-1:0] INSTR,
  output logic [ICWIDTH-1:0] INSTR_PC,
  input  logic               INSTR_READY,
  input  logic               BRANCH,
  input  logic               CALL,
  input  logic               RET,
  input  logic [ICWIDTH-1:0] TARGET,
  output logic               STACK_ERR
);

  localparam int SPW = $clog2(SDEPTH + 1);
  localparam int SIW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam logic [ICWIDTH-1:0] RST_PC  = ICWIDTH'(RESET_ADDR);
  localparam logic [SPW-1:0]     SP_FULL = SPW'(SDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_e;

  state_e               state_q;
  logic [ICWIDTH-1:0]   pc_q, pc_d;
  logic [ICWIDTH-1:0]   instr_pc_q;
  logic [ICWIDTH-1:0]   seq_pc;
  logic [IWWIDTH-1:0]   instr_q;
  logic                 start_q;
  logic                 valid_q;
  logic                 err_q, err_d;
  logic [SPW-1:0]       sp_q, sp_d, top_sp;
  logic [ICWIDTH-1:0]   stack_q [SDEPTH];
  logic                 accept;
  logic                 push;

  // Next-PC selection; only consumed in the accept cycle, so RET/CALL/BRANCH
  // have no effect at any other time.
  always_comb begin
    accept = (state_q == S_HOLD) && INSTR_READY;
    seq_pc = instr_pc_q + ICWIDTH'(1);
    top_sp = sp_q - SPW'(1);
    pc_d   = seq_pc;
    sp_d   = sp_q;
    err_d  = err_q;
    push   = 1'b0;
    if (RET) begin
      if (sp_q != '0) begin
        pc_d = stack_q[top_sp[SIW-1:0]];
        sp_d = top_sp;
      end else begin
        err_d = 1'b1;
      end
    end else if (CALL) begin
      pc_d = TARGET;
      if (sp_q != SP_FULL) begin
        push = accept;
        sp_d = sp_q + SPW'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (BRANCH) begin
      pc_d = TARGET;
    end
  end

  // Return-stack storage holds only data; emptiness is tracked by sp_q alone.
  always_ff @(posedge CLK) begin
    if (push) stack_q[sp_q[SIW-1:0]] <= seq_pc;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pc_q       <= RST_PC;
      sp_q       <= '0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          start_q <= ENABLE;
          if (ENABLE) state_q <= S_FETCH;
        end
        S_FETCH: begin
          start_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!NVM_STALL) begin
            instr_q    <= NVM_INSTRUCTION;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (INSTR_READY) begin
            valid_q <= 1'b0;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            start_q <= ENABLE;
            state_q <= ENABLE ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign NVM_START   = start_q;
  assign NVM_ADDRESS = pc_q;
  assign INSTR_VALID = valid_q;
  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign STACK_ERR   = err_q;

endmodule
